lane_release_ctrl: RTL

//   Receive-side buffer-release scheduler for the JESD204B RX.
//   - Generates the SYSREF-aligned LMFC tick, which also feeds the link control FSM's lmfc_clk_i.
//   - Tracks per-lane ILAS-start arrival and checks inter-lane skew.
//   - Releases all lane elastic buffers together at a fixed LMFC phase (RBD), giving deterministic latency.
//   - Sits between the link control FSM (ifs_rst) and the per-lane alignment buffers.

---
 rtl/lane_release_ctrl_pkg.sv | 19 +
 rtl/lane_release_ctrl_if.sv | 29 ++
 rtl/lane_release_ctrl_lmfc_gen.sv | 63 ++++++
 rtl/lane_release_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/lane_release_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : jesd_rx_pkg                                                     |
// | Brief    : Shared types for the JESD204B RX buffer-release scheduler.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package jesd_rx_pkg;

  localparam int unsigned LMFC_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ILAS = 2'd1,
    ST_WAIT_RBD  = 2'd2,
    ST_RELEASED  = 2'd3
  } rel_state_e;

endpackage
`default_nettype wire

// File: rtl/lane_release_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : lane_release_ctrl_if                                           |
// | Brief     : Per-lane control/status between link FSM, lanes and scheduler. |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface lane_release_ctrl_if #(
  parameter int L = 1
) ();
  logic [L-1:0] lane_disable_i;
  logic [L-1:0] ifs_rst_i;
  logic [L-1:0] ilas_start_i;
  logic         buf_release_o;

  modport master (
    output lane_disable_i,
    output ifs_rst_i,
    output ilas_start_i,
    input  buf_release_o
  );

  modport slave (
    input  lane_disable_i,
    input  ifs_rst_i,
    input  ilas_start_i,
    output buf_release_o
  );
endinterface
`default_nettype wire

// File: rtl/lane_release_ctrl_lmfc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lmfc_gen                                                        |
// | Brief    : SYSREF-aligned LMFC counter with lock and off-phase detection.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lmfc_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] cfg_lmfc_period_i,
  input  logic             sysref_i,
  input  logic             realign_en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             lmfc_clk_o,
  output logic             locked_o,
  output logic             sysref_err_o
);

  logic             r_sysref_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_locked;
  logic             r_sysref_err;
  logic             w_edge;
  logic             w_realign;
  logic             w_wrap;

  assign w_edge    = sysref_i & ~r_sysref_q;
  assign w_realign = w_edge & realign_en_i;
  assign w_wrap    = (r_cnt >= cfg_lmfc_period_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sysref_q   <= 1'b0;
      r_cnt        <= '0;
      r_locked     <= 1'b0;
      r_sysref_err <= 1'b0;
    end else begin
      r_sysref_q <= sysref_i;
      if (w_realign || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_realign) begin
        r_locked <= 1'b1;
      end
      // Once realign is closed, a healthy SYSREF lands on the last count of a period.
      if (w_edge && !realign_en_i && (r_cnt != cfg_lmfc_period_i)) begin
        r_sysref_err <= 1'b1;
      end
    end
  end

  assign cnt_o        = r_cnt;
  // The counter free-runs from reset; ticks are only meaningful once aligned.
  assign lmfc_clk_o   = r_locked & (r_cnt == '0);
  assign locked_o     = r_locked;
  assign sysref_err_o = r_sysref_err;

endmodule
`default_nettype wire

// File: rtl/lane_release_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lane_release_ctrl                                               |
// | Brief    : Releases all RX lane buffers together at a fixed LMFC phase.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lane_release_ctrl
  import jesd_rx_pkg::*;
#(
  parameter int L     = 1,
  parameter int CNT_W = LMFC_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CNT_W-1:0]     cfg_lmfc_period_i,
  input  logic [CNT_W-1:0]     cfg_rbd_i,
  input  logic                 sysref_i,
  lane_release_ctrl_if.slave   lane_if,
  output logic                 lmfc_clk_o,
  output logic                 lmfc_locked_o,
  output logic                 sysref_err_o,
  output logic                 align_err_o
);

  rel_state_e       r_state, w_state_d;
  logic [L-1:0]     r_arrived, w_arrived_d, w_arr_next, w_lane_en;
  logic [CNT_W:0]   r_skew, w_skew_d, w_skew_limit;
  logic             r_align_err, w_align_err_d;
  logic             r_rbd_entry;
  logic [CNT_W-1:0] w_cnt;
  logic             w_ifs_block, w_all_arrived, w_skew_expired, w_rbd_hit;

  lmfc_gen #(.CNT_W(CNT_W)) u_lmfc_gen (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .cfg_lmfc_period_i (cfg_lmfc_period_i),
    .sysref_i          (sysref_i),
    .realign_en_i      (r_state == ST_IDLE),
    .cnt_o             (w_cnt),
    .lmfc_clk_o        (lmfc_clk_o),
    .locked_o          (lmfc_locked_o),
    .sysref_err_o      (sysref_err_o)
  );

  assign w_lane_en      = ~lane_if.lane_disable_i;
  assign w_ifs_block    = |(lane_if.ifs_rst_i & w_lane_en);
  assign w_arr_next     = r_arrived | (lane_if.ilas_start_i & w_lane_en);
  assign w_all_arrived  = &(w_arr_next | lane_if.lane_disable_i);
  assign w_skew_limit   = {1'b0, cfg_lmfc_period_i} + {{CNT_W{1'b0}}, 1'b1};
  assign w_skew_expired = (r_skew == w_skew_limit);
  // The entry cycle is excluded so a phase match there costs a full period.
  assign w_rbd_hit      = (w_cnt == cfg_rbd_i) && !r_rbd_entry;

  always_comb begin
    w_state_d     = r_state;
    w_arrived_d   = r_arrived;
    w_skew_d      = r_skew;
    w_align_err_d = r_align_err;
    case (r_state)
      ST_IDLE: begin
        if (lmfc_locked_o && !w_ifs_block) w_state_d = ST_WAIT_ILAS;
      end
      ST_WAIT_ILAS: begin
        w_arrived_d = w_arr_next;
        if (|w_arr_next) w_skew_d = r_skew + {{CNT_W{1'b0}}, 1'b1};
        if (w_all_arrived) begin
          w_state_d = ST_WAIT_RBD;
        end else if (w_skew_expired) begin
          w_align_err_d = 1'b1;
          w_state_d     = ST_IDLE;
        end
      end
      ST_WAIT_RBD: begin
        if (w_rbd_hit) w_state_d = ST_RELEASED;
      end
      ST_RELEASED: begin
        w_state_d = ST_RELEASED;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
    // An enabled lane in IFS reset overrides every other transition.
    if ((r_state != ST_IDLE) && w_ifs_block) begin
      w_state_d     = ST_IDLE;
      w_align_err_d = r_align_err;
    end
    if (w_state_d == ST_IDLE) begin
      w_arrived_d = '0;
      w_skew_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_arrived   <= '0;
      r_skew      <= '0;
      r_align_err <= 1'b0;
      r_rbd_entry <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_arrived   <= w_arrived_d;
      r_skew      <= w_skew_d;
      r_align_err <= w_align_err_d;
      r_rbd_entry <= (w_state_d == ST_WAIT_RBD) && (r_state != ST_WAIT_RBD);
    end
  end

  assign lane_if.buf_release_o = (r_state == ST_RELEASED);
  assign align_err_o           = r_align_err;

endmodule
`default_nettype wire
